// File: rtl/screen_text_writer.sv
// rtl/screen_text_writer.sv - text-mode framebuffer writer: char stream in, cursor tracking, text-memory writes
// Optional row auto-clear on wrap is enabled by defining SCREEN_TXT_AUTOCLR_EN.
module screen_text_writer #(
   parameter int         TEXT_ROWS = 28,
   parameter int         TEXT_COLS = 52,
   parameter int         AW        = 19,
   parameter logic [7:0] BLANK_CHR = 8'h20
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [7:0]    in_chr,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [7:0]    wr_dat,
   output logic [4:0]    cur_row,
   output logic [5:0]    cur_col,
   output logic          busy
);

   localparam logic [10:0] SCR_LAST = 11'(TEXT_ROWS * TEXT_COLS - 1);
   localparam logic [10:0] ROW_LAST = 11'(TEXT_COLS - 1);
   localparam logic [4:0]  ROW_MAX  = 5'(TEXT_ROWS - 1);
   localparam logic [5:0]  COL_MAX  = 6'(TEXT_COLS - 1);

   typedef enum logic [1:0] {IDLE, CLR_SCR, CLR_ROW} state_t;

   state_t      state, state_nxt;
   logic [10:0] cnt, cnt_nxt;
   logic [4:0]  row_nxt;
   logic [5:0]  col_nxt;
   logic        we_nxt;
   logic [10:0] addr_nxt;
   logic [7:0]  dat_nxt;
   logic        accept;

   function automatic logic [10:0] lin(input logic [4:0] r, input logic [5:0] c);
      return 11'(r) * 11'(TEXT_COLS) + 11'(c);
   endfunction

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= CLR_SCR;
         cnt      <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_dat   <= '0;
         cur_row  <= '0;
         cur_col  <= '0;
         in_ready <= 1'b0;
         busy     <= 1'b1;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         wr_en    <= we_nxt;
         wr_addr  <= AW'(addr_nxt);
         wr_dat   <= dat_nxt;
         cur_row  <= row_nxt;
         cur_col  <= col_nxt;
         // ready only once IDLE has been held for a full cycle, so it trails the last clear write
         in_ready <= (state == IDLE) && (state_nxt == IDLE);
         busy     <= !((state == IDLE) && (state_nxt == IDLE));
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      row_nxt   = cur_row;
      col_nxt   = cur_col;
      we_nxt    = 1'b0;
      addr_nxt  = wr_addr[10:0];
      dat_nxt   = wr_dat;
      case (state)
         CLR_SCR: begin
            we_nxt   = 1'b1;
            addr_nxt = cnt;
            dat_nxt  = BLANK_CHR;
            cnt_nxt  = cnt + 11'd1;
            if (cnt == SCR_LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               row_nxt   = '0;
               col_nxt   = '0;
            end
         end
         CLR_ROW: begin
            we_nxt   = 1'b1;
            addr_nxt = lin(cur_row, 6'd0) + cnt;
            dat_nxt  = BLANK_CHR;
            cnt_nxt  = cnt + 11'd1;
            if (cnt == ROW_LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               col_nxt   = '0;
            end
         end
         default: begin
            if (accept) begin
               case (in_chr)
                  8'h0A: begin
                     col_nxt = '0;
                     if (cur_row == ROW_MAX) begin
                        row_nxt = '0;
`ifdef SCREEN_TXT_AUTOCLR_EN
                        state_nxt = CLR_ROW;
`endif
                     end else begin
                        row_nxt = cur_row + 5'd1;
                     end
                  end
                  8'h0D: col_nxt = '0;
                  8'h08: begin
                     if (cur_col != 6'd0) begin
                        col_nxt  = cur_col - 6'd1;
                        we_nxt   = 1'b1;
                        addr_nxt = lin(cur_row, cur_col - 6'd1);
                        dat_nxt  = BLANK_CHR;
                     end else if (cur_row != 5'd0) begin
                        row_nxt  = cur_row - 5'd1;
                        col_nxt  = COL_MAX;
                        we_nxt   = 1'b1;
                        addr_nxt = lin(cur_row - 5'd1, COL_MAX);
                        dat_nxt  = BLANK_CHR;
                     end
                  end
                  8'h0C: begin
                     state_nxt = CLR_SCR;
                     cnt_nxt   = '0;
                  end
                  default: begin
                     we_nxt   = 1'b1;
                     addr_nxt = lin(cur_row, cur_col);
                     dat_nxt  = in_chr;
                     if (cur_col == COL_MAX) begin
                        col_nxt = '0;
                        if (cur_row == ROW_MAX) begin
                           row_nxt = '0;
`ifdef SCREEN_TXT_AUTOCLR_EN
                           state_nxt = CLR_ROW;
`endif
                        end else begin
                           row_nxt = cur_row + 5'd1;
                        end
                     end else begin
                        col_nxt = cur_col + 6'd1;
                     end
                  end
               endcase
            end
         end
      endcase
   end

endmodule

// File: tb/tb_screen_text_writer.sv
// tb/tb_screen_text_writer.sv - self-checking bench for screen_text_writer
// Reference model tracks a linear cursor position and a full shadow of text memory.
module tb_screen_text_writer;

   localparam int ROWS  = 28;
   localparam int COLS  = 52;
   localparam int CELLS = ROWS * COLS;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_chr = 8'h00;
   logic        wr_en;
   logic [18:0] wr_addr;
   logic [7:0]  wr_dat;
   logic [4:0]  cur_row;
   logic [5:0]  cur_col;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int oob = 0;

   logic [7:0] m_mem [CELLS];
   logic [7:0] dut_mem [CELLS];
   int m_row, m_col;
   bit exp_we;
   int exp_addr;
   logic [7:0] exp_dat;

   logic        obs_we;
   logic [18:0] obs_addr;
   logic [7:0]  obs_dat;
   logic [4:0]  obs_row;
   logic [5:0]  obs_col;

   screen_text_writer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_chr(in_chr),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_dat(wr_dat),
      .cur_row(cur_row), .cur_col(cur_col), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         if (wr_addr < 19'(CELLS)) dut_mem[wr_addr[10:0]] = wr_dat;
         else oob++;
      end
   end

   task automatic model_apply(input logic [7:0] c);
      int p;
      p = m_row * COLS + m_col;
      exp_we = 0;
      exp_addr = 0;
      exp_dat = 8'h20;
      case (c)
         8'h0A: begin m_col = 0; m_row = m_row + 1; end
         8'h0D: m_col = 0;
         8'h08: if (p > 0) begin
            p--;
            exp_we = 1; exp_addr = p; m_mem[p] = 8'h20;
            m_row = p / COLS; m_col = p % COLS;
         end
         8'h0C: begin
            for (int i = 0; i < CELLS; i++) m_mem[i] = 8'h20;
            m_row = 0; m_col = 0;
         end
         default: begin
            exp_we = 1; exp_addr = p; exp_dat = c; m_mem[p] = c;
            p++;
            m_row = p / COLS; m_col = p % COLS;
         end
      endcase
      if (m_row == ROWS) begin
         m_row = 0;
`ifdef SCREEN_TXT_AUTOCLR_EN
         for (int i = 0; i < COLS; i++) m_mem[i] = 8'h20;
`endif
      end
   endtask

   task automatic drive_chr(input logic [7:0] c);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_timeout: in_ready=%b required 1", in_ready);
      end
      in_valid = 1'b1;
      in_chr = c;
      @(negedge clk);
      in_valid = 1'b0;
      obs_we = wr_en; obs_addr = wr_addr; obs_dat = wr_dat;
      obs_row = cur_row; obs_col = cur_col;
      model_apply(c);
   endtask

   task automatic test_reset;
      bit ok;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({wr_en, wr_addr, wr_dat, cur_row, cur_col, in_ready, busy} !== {1'b0, 19'd0, 8'd0, 5'd0, 6'd0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_values: we=%b addr=%0d dat=%h row=%0d col=%0d rdy=%b busy=%b required 0,0,00,0,0,0,1",
                  wr_en, wr_addr, wr_dat, cur_row, cur_col, in_ready, busy);
      end
      for (int i = 0; i < CELLS; i++) m_mem[i] = 8'h20;
      m_row = 0; m_col = 0;
      rst = 1'b0;
      for (int i = 0; i < CELLS; i++) begin
         @(negedge clk);
         checks++;
         ok = (wr_en === 1'b1) && (wr_addr === 19'(i)) && (wr_dat === 8'h20) && (busy === 1'b1) && (in_ready === 1'b0);
         if (!ok) begin
            errors++;
            $display("FAIL init_clear[%0d]: we=%b addr=%0d dat=%h busy=%b rdy=%b required 1,%0d,20,1,0",
                     i, wr_en, wr_addr, wr_dat, busy, in_ready, i);
         end
      end
      @(negedge clk);
      checks++;
      if ({wr_en, in_ready, busy, cur_row, cur_col} !== {1'b0, 1'b1, 1'b0, 5'd0, 6'd0}) begin
         errors++;
         $display("FAIL init_clear_done: we=%b rdy=%b busy=%b row=%0d col=%0d required 0,1,0,0,0",
                  wr_en, in_ready, busy, cur_row, cur_col);
      end
   endtask

   task automatic test_back_to_back;
      in_valid = 1'b1;
      in_chr = 8'h41;
      @(negedge clk);
      checks++;
      if ({wr_en, wr_addr, wr_dat} !== {1'b1, 19'd0, 8'h41}) begin
         errors++;
         $display("FAIL b2b_first: we=%b addr=%0d dat=%h required 1,0,41", wr_en, wr_addr, wr_dat);
      end
      in_chr = 8'h42;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if ({wr_en, wr_addr, wr_dat} !== {1'b1, 19'd1, 8'h42}) begin
         errors++;
         $display("FAIL b2b_second: we=%b addr=%0d dat=%h required 1,1,42", wr_en, wr_addr, wr_dat);
      end
      checks++;
      if ({cur_row, cur_col} !== {5'd0, 6'd2}) begin
         errors++;
         $display("FAIL b2b_cursor: row=%0d col=%0d required 0,2", cur_row, cur_col);
      end
      model_apply(8'h41);
      model_apply(8'h42);
   endtask

   task automatic test_wrap;
      drive_chr(8'h0D);
      for (int i = 0; i < COLS; i++) begin
         drive_chr(8'h58);
         checks++;
         if ({obs_we, obs_addr, obs_dat} !== {1'b1, 19'(exp_addr), 8'h58}) begin
            errors++;
            $display("FAIL wrap_fill[%0d]: we=%b addr=%0d dat=%h required 1,%0d,58", i, obs_we, obs_addr, obs_dat, exp_addr);
         end
      end
      drive_chr(8'h59);
      checks++;
      if ({obs_we, obs_addr, obs_dat, obs_row, obs_col} !== {1'b1, 19'd52, 8'h59, 5'd1, 6'd1}) begin
         errors++;
         $display("FAIL wrap_next_row: we=%b addr=%0d dat=%h row=%0d col=%0d required 1,52,59,1,1",
                  obs_we, obs_addr, obs_dat, obs_row, obs_col);
      end
   endtask

   task automatic test_lf_overflow;
      drive_chr(8'h0D);
      for (int i = 0; i < ROWS - 2; i++) drive_chr(8'h0A);
      for (int i = 0; i < 10; i++) drive_chr(8'h41);
      checks++;
      if ({obs_row, obs_col} !== {5'd27, 6'd10}) begin
         errors++;
         $display("FAIL lf_setup_cursor: row=%0d col=%0d required 27,10", obs_row, obs_col);
      end
      drive_chr(8'h0A);
      checks++;
      if ({obs_we, obs_row, obs_col} !== {1'b0, 5'd0, 6'd0}) begin
         errors++;
         $display("FAIL lf_overflow: we=%b row=%0d col=%0d required 0,0,0", obs_we, obs_row, obs_col);
      end
`ifdef SCREEN_TXT_AUTOCLR_EN
      for (int i = 0; i < COLS; i++) begin
         @(negedge clk);
         checks++;
         if ({wr_en, wr_addr, wr_dat, busy} !== {1'b1, 19'(i), 8'h20, 1'b1}) begin
            errors++;
            $display("FAIL row_clear[%0d]: we=%b addr=%0d dat=%h busy=%b required 1,%0d,20,1", i, wr_en, wr_addr, wr_dat, busy, i);
         end
      end
      @(negedge clk);
`endif
      checks++;
      if ({in_ready, cur_row, cur_col} !== {1'b1, 5'd0, 6'd0}) begin
         errors++;
         $display("FAIL lf_overflow_ready: rdy=%b row=%0d col=%0d required 1,0,0", in_ready, cur_row, cur_col);
      end
   endtask

   task automatic test_backspace;
      drive_chr(8'h0A);
      drive_chr(8'h08);
      checks++;
      if ({obs_we, obs_addr, obs_dat, obs_row, obs_col} !== {1'b1, 19'd51, 8'h20, 5'd0, 6'd51}) begin
         errors++;
         $display("FAIL bs_row_back: we=%b addr=%0d dat=%h row=%0d col=%0d required 1,51,20,0,51",
                  obs_we, obs_addr, obs_dat, obs_row, obs_col);
      end
      drive_chr(8'h0D);
      drive_chr(8'h08);
      checks++;
      if ({obs_we, obs_row, obs_col} !== {1'b0, 5'd0, 6'd0}) begin
         errors++;
         $display("FAIL bs_origin: we=%b row=%0d col=%0d required 0,0,0", obs_we, obs_row, obs_col);
      end
   endtask

   task automatic test_random;
      logic [7:0] c;
      int r;
      for (int k = 0; k < 300; k++) begin
         r = $urandom_range(0, 11);
         if (r == 0) c = 8'h0A;
         else if (r == 1) c = 8'h0D;
         else if (r <= 3) c = 8'h08;
         else begin
            c = 8'($urandom_range(0, 255));
            if (c == 8'h08 || c == 8'h0A || c == 8'h0C || c == 8'h0D) c = c | 8'h40;
         end
         drive_chr(c);
         checks++;
         if (obs_we !== exp_we || (exp_we && (obs_addr !== 19'(exp_addr) || obs_dat !== exp_dat))
             || obs_row !== 5'(m_row) || obs_col !== 6'(m_col)) begin
            errors++;
            $display("FAIL random[%0d] chr=%h: we=%b addr=%0d dat=%h row=%0d col=%0d required %b,%0d,%h,%0d,%0d",
                     k, c, obs_we, obs_addr, obs_dat, obs_row, obs_col, exp_we, exp_addr, exp_dat, m_row, m_col);
         end
      end
   endtask

   task automatic test_mem_compare;
      repeat (2) @(negedge clk);
      checks++;
      if (oob != 0) begin
         errors++;
         $display("FAIL addr_range: out-of-range writes=%0d required 0", oob);
      end
      for (int i = 0; i < CELLS; i++) begin
         checks++;
         if (dut_mem[i] !== m_mem[i]) begin
            errors++;
            $display("FAIL mem[%0d]: got %h required %h", i, dut_mem[i], m_mem[i]);
         end
      end
   endtask

   task automatic test_ff_clear_reset;
      int n;
      bit ok;
      while (in_ready !== 1'b1) @(negedge clk);
      in_valid = 1'b1;
      in_chr = 8'h0C;
      @(negedge clk);
      in_chr = 8'h5A;
      model_apply(8'h0C);
      n = 0;
      while (wr_en !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < CELLS; i++) begin
         checks++;
         ok = (wr_en === 1'b1) && (wr_addr === 19'(i)) && (wr_dat === 8'h20) && (busy === 1'b1) && (in_ready === 1'b0);
         if (!ok) begin
            errors++;
            $display("FAIL ff_clear[%0d]: we=%b addr=%0d dat=%h busy=%b rdy=%b required 1,%0d,20,1,0",
                     i, wr_en, wr_addr, wr_dat, busy, in_ready, i);
         end
         @(negedge clk);
      end
      checks++;
      if ({wr_en, in_ready, cur_row, cur_col} !== {1'b0, 1'b1, 5'd0, 6'd0}) begin
         errors++;
         $display("FAIL ff_clear_done: we=%b rdy=%b row=%0d col=%0d required 0,1,0,0", wr_en, in_ready, cur_row, cur_col);
      end
      @(negedge clk);
      in_chr = 8'h0C;
      model_apply(8'h5A);
      checks++;
      if ({wr_en, wr_addr, wr_dat, cur_col} !== {1'b1, 19'd0, 8'h5A, 6'd1}) begin
         errors++;
         $display("FAIL ff_held_after: we=%b addr=%0d dat=%h col=%0d required 1,0,5a,1", wr_en, wr_addr, wr_dat, cur_col);
      end
      @(negedge clk);
      in_valid = 1'b0;
      model_apply(8'h0C);
      n = 0;
      while (!(wr_en === 1'b1 && wr_addr === 19'd700) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (wr_addr !== 19'd700) begin
         errors++;
         $display("FAIL ff_reach_700: addr=%0d required 700", wr_addr);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({wr_en, wr_addr, wr_dat, cur_row, cur_col, in_ready, busy} !== {1'b0, 19'd0, 8'd0, 5'd0, 6'd0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL mid_reset: we=%b addr=%0d dat=%h row=%0d col=%0d rdy=%b busy=%b required 0,0,00,0,0,0,1",
                  wr_en, wr_addr, wr_dat, cur_row, cur_col, in_ready, busy);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < CELLS; i++) begin
         @(negedge clk);
         checks++;
         if ({wr_en, wr_addr, wr_dat, busy} !== {1'b1, 19'(i), 8'h20, 1'b1}) begin
            errors++;
            $display("FAIL restart_clear[%0d]: we=%b addr=%0d dat=%h busy=%b required 1,%0d,20,1", i, wr_en, wr_addr, wr_dat, busy, i);
         end
      end
      @(negedge clk);
      checks++;
      if ({in_ready, busy} !== {1'b1, 1'b0}) begin
         errors++;
         $display("FAIL restart_done: rdy=%b busy=%b required 1,0", in_ready, busy);
      end
   endtask

   initial begin
      test_reset;
      test_back_to_back;
      test_wrap;
      test_lf_overflow;
      test_backspace;
      test_random;
      test_mem_compare;
      test_ff_clear_reset;
      test_mem_compare;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
